// File: rtl/mdio_arbiter_pkg.sv
// Purpose: shared types for the two-port MDIO arbiter.
//   - opcode constants, FSM state encoding, latched command payload
//   - helper that tells a real MDIO opcode from an illegal one
package mdio_arbiter_pkg;

  localparam int unsigned PHY_W  = 5;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 2;

  localparam logic [OP_W-1:0] OP_WRITE = 2'b01;
  localparam logic [OP_W-1:0] OP_READ  = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  typedef struct packed {
    logic [PHY_W-1:0]  phy_addr;
    logic [REG_W-1:0]  reg_addr;
    logic [DATA_W-1:0] data;
    logic [OP_W-1:0]   opcode;
  } mdio_cmd_t;

  function automatic logic is_mdio_op(input logic [OP_W-1:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/mdio_rr_arb2.sv
// Purpose: two-requester round-robin pick (combinational).
//   req   : request bits, bit i is port i
//   last  : port granted most recently
//   grant : selected port index; meaningless when req == 0
module mdio_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  // Contention goes to the port not served last; otherwise the lone requester.
  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) grant = ~last;
    else              grant = req[1];
  end

endmodule

// File: rtl/mdio_arbiter.sv
// Purpose: arbitrates two command ports onto one MDIO master, one
// transaction at a time, with a per-transaction timeout.
//   s_cmd_*   : per-port command request (valid/ready, packed fields)
//   s_rsp_*   : per-port response (valid/ready), shared data + timeout flag
//   m_cmd_*   : command to the MDIO master (valid/ready)
//   m_data_*  : read data from the MDIO master (valid/ready)
//   m_busy    : MDIO master busy; m_prescale : constant PRESCALE
module mdio_arbiter
  import mdio_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  PRESCALE       = 8'h10
) (
  input  logic        clk125,
  input  logic        reset_n,
  input  logic [1:0]  s_cmd_valid,
  output logic [1:0]  s_cmd_ready,
  input  logic [9:0]  s_cmd_phy_addr,
  input  logic [9:0]  s_cmd_reg_addr,
  input  logic [31:0] s_cmd_data,
  input  logic [3:0]  s_cmd_opcode,
  output logic [1:0]  s_rsp_valid,
  input  logic [1:0]  s_rsp_ready,
  output logic [15:0] s_rsp_data,
  output logic        s_rsp_timeout,
  output logic [4:0]  m_cmd_phy_addr,
  output logic [4:0]  m_cmd_reg_addr,
  output logic [15:0] m_cmd_data,
  output logic [1:0]  m_cmd_opcode,
  output logic        m_cmd_valid,
  input  logic        m_cmd_ready,
  input  logic [15:0] m_data_out,
  input  logic        m_data_out_valid,
  output logic        m_data_out_ready,
  input  logic        m_busy,
  output logic [7:0]  m_prescale
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  mdio_cmd_t        r_cmd;
  logic             r_grant;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cmd_ready;
  logic [1:0]       r_rsp_valid;
  logic [15:0]      r_rsp_data;
  logic             r_rsp_timeout;
  logic             r_m_cmd_valid;
  logic             r_dout_ready;

  logic             w_grant;
  mdio_cmd_t        w_sel;
  logic [1:0]       w_grant_oh;
  logic [1:0]       w_cur_oh;
  logic             w_is_read;
  logic             w_tmo_hit;

  mdio_rr_arb2 u_rr (
    .req   (s_cmd_valid),
    .last  (r_last),
    .grant (w_grant)
  );

  // Fields of whichever port the arbiter is picking this cycle.
  assign w_sel = w_grant ?
    '{phy_addr: s_cmd_phy_addr[9:5], reg_addr: s_cmd_reg_addr[9:5],
      data: s_cmd_data[31:16], opcode: s_cmd_opcode[3:2]} :
    '{phy_addr: s_cmd_phy_addr[4:0], reg_addr: s_cmd_reg_addr[4:0],
      data: s_cmd_data[15:0], opcode: s_cmd_opcode[1:0]};

  assign w_grant_oh = {w_grant, ~w_grant};
  assign w_cur_oh   = {r_grant, ~r_grant};
  assign w_is_read  = (r_cmd.opcode == OP_READ);
  // Counter is cleared at accept, so this edge is the TIMEOUT_CYCLES-th one.
  assign w_tmo_hit  = (r_cnt == CNT_LAST);

  // Arbitration / transaction FSM with registered outputs.
  always_ff @(posedge clk125 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_cmd         <= '0;
      r_grant       <= 1'b0;
      r_last        <= 1'b1;
      r_cnt         <= '0;
      r_cmd_ready   <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
      r_m_cmd_valid <= 1'b0;
      r_dout_ready  <= 1'b0;
    end else begin
      r_cmd_ready  <= '0;
      // Read data is always drained; it is only kept in the wait states of a read.
      r_dout_ready <= 1'b1;
      case (r_state)
        IDLE: begin
          if (|s_cmd_valid) begin
            r_grant       <= w_grant;
            r_last        <= w_grant;
            r_cmd_ready   <= w_grant_oh;
            r_cmd         <= w_sel;
            r_cnt         <= '0;
            r_rsp_timeout <= 1'b0;
            if (is_mdio_op(w_sel.opcode)) begin
              r_m_cmd_valid <= 1'b1;
              r_state       <= ISSUE;
            end else begin
              // Illegal opcode: answered at once, master never sees it.
              r_rsp_valid   <= w_grant_oh;
              r_rsp_data    <= '0;
              r_rsp_timeout <= 1'b1;
              r_state       <= RESP;
            end
          end
        end
        ISSUE, WAIT_BUSY, WAIT_DONE: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
          if (w_tmo_hit) begin
            r_m_cmd_valid <= 1'b0;
            r_rsp_valid   <= w_cur_oh;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b1;
            r_state       <= RESP;
          end else if (r_state == ISSUE) begin
            if (m_cmd_ready) begin
              r_m_cmd_valid <= 1'b0;
              r_state       <= WAIT_BUSY;
            end
          end else if (w_is_read) begin
            // Read data may beat busy; either wait state accepts it.
            if (m_data_out_valid) begin
              r_rsp_data  <= m_data_out;
              r_rsp_valid <= w_cur_oh;
              r_state     <= RESP;
            end else if (r_state == WAIT_BUSY && m_busy) begin
              r_state <= WAIT_DONE;
            end
          end else if (r_state == WAIT_BUSY) begin
            if (m_busy) r_state <= WAIT_DONE;
          end else if (!m_busy) begin
            r_rsp_data  <= '0;
            r_rsp_valid <= w_cur_oh;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (s_rsp_ready[r_grant]) begin
            r_rsp_valid <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_cmd_ready      = r_cmd_ready;
  assign s_rsp_valid      = r_rsp_valid;
  assign s_rsp_data       = r_rsp_data;
  assign s_rsp_timeout    = r_rsp_timeout;
  assign m_cmd_phy_addr   = r_cmd.phy_addr;
  assign m_cmd_reg_addr   = r_cmd.reg_addr;
  assign m_cmd_data       = r_cmd.data;
  assign m_cmd_opcode     = r_cmd.opcode;
  assign m_cmd_valid      = r_m_cmd_valid;
  assign m_data_out_ready = r_dout_ready;
  assign m_prescale       = PRESCALE;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed bench for mdio_arbiter; inputs change and outputs are sampled
// on the falling edge of clk125.
module tb_mdio_arbiter;

  logic        clk125 = 1'b0;
  logic        reset_n;
  logic [1:0]  s_cmd_valid;
  logic [1:0]  s_cmd_ready;
  logic [9:0]  s_cmd_phy_addr;
  logic [9:0]  s_cmd_reg_addr;
  logic [31:0] s_cmd_data;
  logic [3:0]  s_cmd_opcode;
  logic [1:0]  s_rsp_valid;
  logic [1:0]  s_rsp_ready;
  logic [15:0] s_rsp_data;
  logic        s_rsp_timeout;
  logic [4:0]  m_cmd_phy_addr;
  logic [4:0]  m_cmd_reg_addr;
  logic [15:0] m_cmd_data;
  logic [1:0]  m_cmd_opcode;
  logic        m_cmd_valid;
  logic        m_cmd_ready;
  logic [15:0] m_data_out;
  logic        m_data_out_valid;
  logic        m_data_out_ready;
  logic        m_busy;
  logic [7:0]  m_prescale;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk125 = ~clk125;

  mdio_arbiter #(.TIMEOUT_CYCLES(100), .PRESCALE(8'h10)) dut (
    .clk125           (clk125),
    .reset_n          (reset_n),
    .s_cmd_valid      (s_cmd_valid),
    .s_cmd_ready      (s_cmd_ready),
    .s_cmd_phy_addr   (s_cmd_phy_addr),
    .s_cmd_reg_addr   (s_cmd_reg_addr),
    .s_cmd_data       (s_cmd_data),
    .s_cmd_opcode     (s_cmd_opcode),
    .s_rsp_valid      (s_rsp_valid),
    .s_rsp_ready      (s_rsp_ready),
    .s_rsp_data       (s_rsp_data),
    .s_rsp_timeout    (s_rsp_timeout),
    .m_cmd_phy_addr   (m_cmd_phy_addr),
    .m_cmd_reg_addr   (m_cmd_reg_addr),
    .m_cmd_data       (m_cmd_data),
    .m_cmd_opcode     (m_cmd_opcode),
    .m_cmd_valid      (m_cmd_valid),
    .m_cmd_ready      (m_cmd_ready),
    .m_data_out       (m_data_out),
    .m_data_out_valid (m_data_out_valid),
    .m_data_out_ready (m_data_out_ready),
    .m_busy           (m_busy),
    .m_prescale       (m_prescale)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic p, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [15:0] d);
    if (p) begin
      s_cmd_phy_addr[9:5] = phy; s_cmd_reg_addr[9:5] = ra;
      s_cmd_data[31:16]   = d;   s_cmd_opcode[3:2]   = op;
      s_cmd_valid[1]      = 1'b1;
    end else begin
      s_cmd_phy_addr[4:0] = phy; s_cmd_reg_addr[4:0] = ra;
      s_cmd_data[15:0]    = d;   s_cmd_opcode[1:0]   = op;
      s_cmd_valid[0]      = 1'b1;
    end
  endtask

  task automatic wait_ready(input logic p, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk125);
      if (s_cmd_ready[p]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_any_ready(output bit ok, output logic g);
    ok = 1'b0; g = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk125);
      if (|s_cmd_ready) begin ok = 1'b1; g = s_cmd_ready[1]; break; end
    end
  endtask

  // Returns one falling edge after the master-side command handshake.
  task automatic master_accept(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (m_cmd_valid) begin ok = 1'b1; break; end
      @(negedge clk125);
    end
    @(negedge clk125);
  endtask

  task automatic take_rsp(input logic p, output bit ok, output logic [15:0] d, output logic t);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (s_rsp_valid[p]) begin ok = 1'b1; break; end
      @(negedge clk125);
    end
    d = s_rsp_data;
    t = s_rsp_timeout;
    if (ok) begin
      s_rsp_ready[p] = 1'b1;
      @(negedge clk125);
      s_rsp_ready = 2'b00;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    bit          seen;
    bit          hold;
    logic        g;
    logic [15:0] d;
    logic        t;
    int          k;
    int          left [2];

    reset_n = 1'b0;
    s_cmd_valid = '0; s_cmd_phy_addr = '0; s_cmd_reg_addr = '0;
    s_cmd_data = '0; s_cmd_opcode = '0; s_rsp_ready = '0;
    m_cmd_ready = 1'b1; m_data_out = '0; m_data_out_valid = 1'b0; m_busy = 1'b0;

    // Reset state
    repeat (3) @(negedge clk125);
    check("rst_cmd_ready",  32'(s_cmd_ready), 32'h0);
    check("rst_rsp_valid",  32'(s_rsp_valid), 32'h0);
    check("rst_rsp_data",   32'(s_rsp_data), 32'h0);
    check("rst_rsp_tmo",    32'(s_rsp_timeout), 32'h0);
    check("rst_m_cmd_valid", 32'(m_cmd_valid), 32'h0);
    check("rst_dout_ready", 32'(m_data_out_ready), 32'h0);
    check("prescale",       32'(m_prescale), 32'h10);
    reset_n = 1'b1;
    @(negedge clk125);
    check("post_rst_dout_ready", 32'(m_data_out_ready), 32'h1);

    // Port 0 read phy 1 reg 2 returning 16'h796D
    set_cmd(1'b0, 2'b10, 5'd1, 5'd2, 16'h0000);
    wait_ready(1'b0, ok);
    check("rd_grant", 32'(ok), 32'h1);
    check("rd_m_valid", 32'(m_cmd_valid), 32'h1);
    check("rd_m_phy", 32'(m_cmd_phy_addr), 32'h1);
    check("rd_m_reg", 32'(m_cmd_reg_addr), 32'h2);
    check("rd_m_op", 32'(m_cmd_opcode), 32'h2);
    master_accept(ok);
    check("rd_accept", 32'(ok), 32'h1);
    s_cmd_valid[0] = 1'b0;
    check("rd_m_valid_drop", 32'(m_cmd_valid), 32'h0);
    m_busy = 1'b1;
    @(negedge clk125);
    check("rd_dout_ready", 32'(m_data_out_ready), 32'h1);
    m_data_out = 16'h796D; m_data_out_valid = 1'b1;
    @(negedge clk125);
    m_data_out_valid = 1'b0; m_busy = 1'b0;
    check("rd_rsp_valid", 32'(s_rsp_valid), 32'h1);
    check("rd_rsp_data", 32'(s_rsp_data), 32'h796D);
    check("rd_rsp_tmo", 32'(s_rsp_timeout), 32'h0);
    s_rsp_ready = 2'b01;
    @(negedge clk125);
    s_rsp_ready = 2'b00;
    check("rd_rsp_done", 32'(s_rsp_valid), 32'h0);

    // Port 1 write 16'h1200 with busy high for 40 cycles
    set_cmd(1'b1, 2'b01, 5'd3, 5'd4, 16'h1200);
    wait_ready(1'b1, ok);
    check("wr_grant", 32'(ok), 32'h1);
    check("wr_m_op", 32'(m_cmd_opcode), 32'h1);
    check("wr_m_data", 32'(m_cmd_data), 32'h1200);
    master_accept(ok);
    s_cmd_valid[1] = 1'b0;
    m_busy = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk125);
      if (s_rsp_valid != 2'b00) seen = 1'b1;
    end
    check("wr_no_early_rsp", 32'(seen), 32'h0);
    m_busy = 1'b0;
    check("wr_rsp_before", 32'(s_rsp_valid), 32'h0);
    @(negedge clk125);
    check("wr_rsp_valid", 32'(s_rsp_valid), 32'h2);
    check("wr_rsp_data", 32'(s_rsp_data), 32'h0);
    check("wr_rsp_tmo", 32'(s_rsp_timeout), 32'h0);
    s_rsp_ready = 2'b10;
    @(negedge clk125);
    s_rsp_ready = 2'b00;
    check("wr_rsp_done", 32'(s_rsp_valid), 32'h0);

    // Both ports, three writes each: grants must alternate 0,1,0,1,0,1
    s_cmd_data = {16'h5A51, 16'hA5A0};
    s_cmd_opcode = 4'b0101;
    s_cmd_valid = 2'b11;
    left[0] = 3; left[1] = 3;
    for (int i = 0; i < 6; i++) begin
      wait_any_ready(ok, g);
      check("rr_ready", 32'(ok), 32'h1);
      check("rr_grant", 32'(g), 32'(i % 2));
      check("rr_m_data", 32'(m_cmd_data), g ? 32'h5A51 : 32'hA5A0);
      master_accept(ok);
      left[g] = left[g] - 1;
      if (left[g] == 0) s_cmd_valid[g] = 1'b0;
      m_busy = 1'b1;
      repeat (2) @(negedge clk125);
      m_busy = 1'b0;
      take_rsp(g, ok, d, t);
      check("rr_rsp", 32'(ok), 32'h1);
    end

    // Timeout: master never accepts the command
    m_cmd_ready = 1'b0;
    set_cmd(1'b0, 2'b10, 5'd5, 5'd6, 16'h0000);
    wait_ready(1'b0, ok);
    check("tmo_grant", 32'(ok), 32'h1);
    k = 0; hold = 1'b1;
    while (!s_rsp_valid[0] && k < 150) begin
      @(negedge clk125);
      k++;
      if (k == 1) s_cmd_valid[0] = 1'b0;
      if (!s_rsp_valid[0] && !m_cmd_valid) hold = 1'b0;
    end
    check("tmo_cycles", 32'(k), 32'd100);
    check("tmo_cmd_held", 32'(hold), 32'h1);
    check("tmo_flag", 32'(s_rsp_timeout), 32'h1);
    check("tmo_data", 32'(s_rsp_data), 32'h0);
    check("tmo_m_valid_drop", 32'(m_cmd_valid), 32'h0);
    s_rsp_ready = 2'b01;
    @(negedge clk125);
    s_rsp_ready = 2'b00;
    m_cmd_ready = 1'b1;
    check("tmo_rsp_done", 32'(s_rsp_valid), 32'h0);

    // Reset in WAIT_DONE, stale read data afterwards
    set_cmd(1'b0, 2'b10, 5'd7, 5'd8, 16'h0000);
    wait_ready(1'b0, ok);
    master_accept(ok);
    s_cmd_valid[0] = 1'b0;
    m_busy = 1'b1;
    repeat (2) @(negedge clk125);
    reset_n = 1'b0;
    @(negedge clk125);
    check("mrst_rsp_valid", 32'(s_rsp_valid), 32'h0);
    check("mrst_m_valid", 32'(m_cmd_valid), 32'h0);
    check("mrst_dout_ready", 32'(m_data_out_ready), 32'h0);
    reset_n = 1'b1; m_busy = 1'b0;
    @(negedge clk125);
    m_data_out = 16'hBEEF; m_data_out_valid = 1'b1;
    check("stale_dout_ready", 32'(m_data_out_ready), 32'h1);
    seen = 1'b0;
    @(negedge clk125);
    m_data_out_valid = 1'b0;
    if (s_rsp_valid != 2'b00) seen = 1'b1;
    repeat (10) begin
      @(negedge clk125);
      if (s_rsp_valid != 2'b00) seen = 1'b1;
    end
    check("stale_no_rsp", 32'(seen), 32'h0);
    set_cmd(1'b1, 2'b10, 5'd9, 5'd10, 16'h0000);
    wait_ready(1'b1, ok);
    check("mrst_next_grant", 32'(ok), 32'h1);
    master_accept(ok);
    s_cmd_valid[1] = 1'b0;
    m_busy = 1'b1;
    @(negedge clk125);
    m_data_out = 16'h1234; m_data_out_valid = 1'b1;
    @(negedge clk125);
    m_data_out_valid = 1'b0; m_busy = 1'b0;
    take_rsp(1'b1, ok, d, t);
    check("mrst_next_rsp", 32'(ok), 32'h1);
    check("mrst_next_data", 32'(d), 32'h1234);
    check("mrst_next_tmo", 32'(t), 32'h0);

    // Response stalled 20 cycles while port 1 waits
    set_cmd(1'b0, 2'b10, 5'd11, 5'd12, 16'h0000);
    wait_ready(1'b0, ok);
    master_accept(ok);
    s_cmd_valid[0] = 1'b0;
    m_busy = 1'b1;
    @(negedge clk125);
    m_data_out = 16'hC3A5; m_data_out_valid = 1'b1;
    @(negedge clk125);
    m_data_out_valid = 1'b0; m_busy = 1'b0;
    set_cmd(1'b1, 2'b01, 5'd13, 5'd14, 16'h0042);
    repeat (20) begin
      @(negedge clk125);
      check("stall_valid", 32'(s_rsp_valid), 32'h1);
      check("stall_data", 32'(s_rsp_data), 32'hC3A5);
      check("stall_no_grant", 32'(s_cmd_ready), 32'h0);
    end
    s_rsp_ready = 2'b01;
    @(negedge clk125);
    s_rsp_ready = 2'b00;
    check("stall_rsp_done", 32'(s_rsp_valid), 32'h0);
    check("stall_no_same_cycle_grant", 32'(s_cmd_ready), 32'h0);
    @(negedge clk125);
    check("stall_next_grant", 32'(s_cmd_ready), 32'h2);
    master_accept(ok);
    s_cmd_valid[1] = 1'b0;
    m_busy = 1'b1;
    repeat (2) @(negedge clk125);
    m_busy = 1'b0;
    take_rsp(1'b1, ok, d, t);
    check("stall_next_rsp", 32'(ok), 32'h1);
    check("stall_next_data", 32'(d), 32'h0);

    // Illegal opcodes answered at once with timeout, no MDIO access
    for (int p = 0; p < 2; p++) begin
      set_cmd(p[0], p[0] ? 2'b00 : 2'b11, 5'd1, 5'd1, 16'hFFFF);
      wait_ready(p[0], ok);
      check("bad_grant", 32'(ok), 32'h1);
      check("bad_rsp_valid", 32'(s_rsp_valid), p[0] ? 32'h2 : 32'h1);
      check("bad_tmo", 32'(s_rsp_timeout), 32'h1);
      check("bad_data", 32'(s_rsp_data), 32'h0);
      check("bad_no_mdio", 32'(m_cmd_valid), 32'h0);
      s_rsp_ready[p[0]] = 1'b1;
      @(negedge clk125);
      s_cmd_valid = 2'b00; s_rsp_ready = 2'b00;
      check("bad_rsp_done", 32'(s_rsp_valid), 32'h0);
      check("bad_no_mdio_after", 32'(m_cmd_valid), 32'h0);
      @(negedge clk125);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mdio_arbiter.md
MDIO_ARBITER -- requirements
Module: mdio_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65535: max cycles per transaction, counted from command accept to completion.
REQ-002 Parameter PRESCALE, default 8'h10: constant driven on m_prescale.
REQ-003 clk125  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 s_cmd_valid  in  2  per-requester command valid; bit i is port i.
REQ-006 s_cmd_ready  out  2  per-requester command accept.
REQ-007 s_cmd_phy_addr  in  10  port i at [5i+4:5i].
REQ-008 s_cmd_reg_addr  in  10  port i at [5i+4:5i].
REQ-009 s_cmd_data  in  32  port i at [16i+15:16i].
REQ-010 s_cmd_opcode  in  4  port i at [2i+1:2i]; 2'b01 write, 2'b10 read.
REQ-011 s_rsp_valid  out  2  per-port response valid.
REQ-012 s_rsp_ready  in  2  per-port response accept.
REQ-013 s_rsp_data  out  16  read data; 0 for writes and timeouts; shared by both ports.
REQ-014 s_rsp_timeout  out  1  qualifies the current s_rsp_valid bit.
REQ-015 m_cmd_phy_addr/m_cmd_reg_addr/m_cmd_data/m_cmd_opcode  out  5/5/16/2  to MDIO master.
REQ-016 m_cmd_valid out 1, m_cmd_ready in 1  MDIO master command handshake.
REQ-017 m_data_out in 16, m_data_out_valid in 1, m_data_out_ready out 1  MDIO master read data handshake.
REQ-018 m_busy  in 1  MDIO master busy; m_prescale  out 8  = PRESCALE.

Function
REQ-019 States SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-020 IDLE: if any s_cmd_valid is set, grant SHALL be round-robin; priority goes to the port not granted last; port 0 wins the first arbitration after reset.
REQ-021 Grant: pulse s_cmd_ready[g] for one cycle, latch that port's fields, clear the timeout counter, go to ISSUE; grant-to-ready latency 1 cycle from IDLE.
REQ-022 ISSUE: m_cmd_valid=1 with latched fields until m_cmd_ready; on handshake go to WAIT_BUSY.
REQ-023 WAIT_BUSY: on m_busy=1 go to WAIT_DONE; a read whose m_data_out_valid arrives first SHALL go directly to RESP.
REQ-024 WAIT_DONE, read: m_data_out_ready=1; on m_data_out_valid, capture m_data_out into s_rsp_data and go to RESP.
REQ-025 WAIT_DONE, write: on m_busy=0 set s_rsp_data=0 and go to RESP.
REQ-026 The timeout counter SHALL increment in ISSUE/WAIT_BUSY/WAIT_DONE, saturate, and force RESP with s_rsp_timeout=1 when it reaches TIMEOUT_CYCLES.
REQ-027 RESP: hold s_rsp_valid[g] and data stable until s_rsp_ready[g]; then return to IDLE; no new grant in the same cycle.
REQ-028 m_data_out_valid outside WAIT_BUSY/WAIT_DONE SHALL be consumed (m_data_out_ready=1) and discarded.
REQ-029 Opcodes 2'b00/2'b11 SHALL be accepted and answered immediately with s_rsp_timeout=1, data 0, and no MDIO access.
REQ-030 One transaction outstanding at most; s_cmd_ready is 0 outside the IDLE grant cycle; the non-granted port's s_cmd_valid is held off, never dropped.

Reset
REQ-031 On reset_n=0: state IDLE, s_cmd_ready=0, s_rsp_valid=0, s_rsp_data=0, s_rsp_timeout=0, m_cmd_valid=0, m_data_out_ready=0, counter=0, last-grant=port 1.
REQ-032 Reset mid-transaction SHALL abandon it with no response; after release the block SHALL discard the stale read through REQ-028.

Structure
REQ-033 A shared package SHALL hold the opcode constants (OP_WRITE=2'b01, OP_READ=2'b10) and the state encoding.
REQ-034 The round-robin grant SHALL be sub-module mdio_rr_arb2: inputs req[1:0], last; output grant.

Verification
REQ-035 Port 0 read phy 1 reg 2, master returns 16'h796D -> one s_rsp_valid[0] with data 16'h796D and timeout 0.
REQ-036 Both ports assert at once, three commands each -> grants alternate 0,1,0,1,0,1.
REQ-037 Port 1 write data 16'h1200, busy high for 40 cycles -> rsp_valid[1] one cycle after busy falls, data 0.
REQ-038 TIMEOUT_CYCLES=100, m_cmd_ready held 0 -> rsp_valid with timeout=1 after 100 cycles, then IDLE.
REQ-039 reset_n pulsed low during WAIT_DONE, late m_data_out_valid follows -> no response on either port; next command completes normally.
REQ-040 s_rsp_ready held 0 for 20 cycles in RESP -> data stable throughout, no new grant until accept.
